// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Parametrised UART transmitter with an internal write FIFO.
//            Bytes enter through a valid/ready port, are queued, and are
//            serialised LSB-first as start / data / [parity] / stop frames.
//            Frames run back-to-back when the FIFO still holds data at the
//            end of a stop bit.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            wr_valid_i      - write request (level-sensitive)
//            wr_data_i       - data word to transmit (DATA_BITS wide)
//            wr_ready_o      - FIFO can accept a write this cycle
//            txd_o           - serial output, idle high
//            busy_o          - frame in progress or FIFO non-empty
//            fifo_count_o    - entries currently queued
//            done_o          - one-cycle pulse on the last stop-bit cycle
//            brk_i           - break request (only with UART_TX_BREAK_EN)
// Options  : `define UART_TX_BREAK_EN to add the line-break feature: while
//            brk_i is high in IDLE the line is held low and pops are held
//            off; after release the line idles high for one bit time.
// Params   : CLK_DIV 2..65535, DATA_BITS 5..9, PARITY 0/1/2 (none/odd/even),
//            STOP_BITS 1..2, FIFO_DEPTH power of two 2..256
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid_i,
    input  logic [DATA_BITS-1:0]          wr_data_i,
    output logic                          wr_ready_o,
    output logic                          txd_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          done_o
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                          brk_i
`endif
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_iw = $clog2(DATA_BITS);

    localparam logic [15:0]     c_bit_last = 16'(CLK_DIV - 1);
    localparam logic [c_iw-1:0] c_idx_last = c_iw'(DATA_BITS - 1);
    localparam logic            c_stop_last = (STOP_BITS == 2);
`ifdef UART_TX_BREAK_EN
    // The IDLE cycle in which brk_i is seen low already counts as the first
    // cycle of the post-break mark, so the gap state covers the rest.
    localparam logic [15:0]     c_gap_first = 16'(CLK_DIV - 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
`ifdef UART_TX_BREAK_EN
        ,
        S_GAP   = 3'd5
`endif
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [c_aw-1:0]      wr_ptr_q;
    logic [c_aw-1:0]      rd_ptr_q;
    logic [c_cw-1:0]      count_q;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_nempty;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    // FIFO_DEPTH is a power of two, so count < FIFO_DEPTH exactly when the
    // count's top bit is clear.
    assign wr_ready_o    = ~count_q[c_aw];
    assign w_push        = wr_valid_i && wr_ready_o;
    assign w_fifo_nempty = (count_q != '0);
    assign w_head        = mem_q[rd_ptr_q];
    // Odd parity inverts the data XOR so the total number of ones is odd.
    assign w_head_par    = (PARITY == 1) ? ~(^w_head) : (^w_head);

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign fifo_count_o = count_q;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [15:0]          baud_q, baud_d;
    logic [c_iw-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 w_bit_end;
    logic                 w_load;
`ifdef UART_TX_BREAK_EN
    logic                 brk_seen_q, brk_seen_d;
`endif

    assign w_bit_end = (baud_q == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_idx_q <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_seen_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop_idx_q <= stop_idx_d;
`ifdef UART_TX_BREAK_EN
            brk_seen_q <= brk_seen_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop_idx_d = stop_idx_q;
        w_load     = 1'b0;
        w_pop      = 1'b0;
        txd_o      = 1'b1;
        done_o     = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_seen_d = brk_seen_q;
`endif

        // The bit-time counter only runs while a frame (or gap) is active.
        if (state_q != S_IDLE) begin
            baud_d = w_bit_end ? c_bit_last : (baud_q - 16'd1);
        end

        case (state_q)
            S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (brk_i) begin
                    txd_o      = 1'b0;
                    brk_seen_d = 1'b1;
                end else if (brk_seen_q) begin
                    brk_seen_d = 1'b0;
                    baud_d     = c_gap_first;
                    state_d    = S_GAP;
                end else if (w_fifo_nempty) begin
                    w_load = 1'b1;
                end
`else
                if (w_fifo_nempty) begin
                    w_load = 1'b1;
                end
`endif
            end
            S_START: begin
                txd_o = 1'b0;
                if (w_bit_end) begin
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                txd_o = shift_q[0];
                if (w_bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == c_idx_last) begin
                        stop_idx_d = 1'b0;
                        state_d    = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                txd_o = par_q;
                if (w_bit_end) begin
                    stop_idx_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (stop_idx_q == c_stop_last) begin
                        done_o = 1'b1;
                        // Chain straight into the next start bit if data waits.
                        if (w_fifo_nempty) begin
                            w_load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_GAP: begin
                if (w_bit_end) begin
                    if (w_fifo_nempty) begin
                        w_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_pop   = 1'b1;
            shift_d = w_head;
            par_d   = w_head_par;
            baud_d  = c_bit_last;
            state_d = S_START;
        end
    end

    assign busy_o = (state_q != S_IDLE) || w_fifo_nempty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo. Three differently
//            configured instances share one stimulus stream; a waveform-level
//            reference model (queued words, expanded per-cycle frame bits)
//            predicts txd, done, busy, fifo_count and wr_ready every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int N = 3;

    // Per-instance configuration, mirrored in the instantiations below.
    int cd  [N] = '{4, 4, 2};
    int db  [N] = '{8, 8, 5};
    int par [N] = '{0, 2, 1};
    int sb  [N] = '{1, 2, 1};
    int dep [N] = '{4, 8, 2};

    logic       clk;
    logic       rst;
    logic       wv;
    logic [8:0] wd;
`ifdef UART_TX_BREAK_EN
    logic       brk;
`endif

    logic        txd_w  [N];
    logic        done_w [N];
    logic        busy_w [N];
    logic        rdy_w  [N];
    logic [31:0] cnt_w  [N];
    logic [2:0]  cnt0;
    logic [3:0]  cnt1;
    logic [1:0]  cnt2;

    assign cnt_w[0] = {29'd0, cnt0};
    assign cnt_w[1] = {28'd0, cnt1};
    assign cnt_w[2] = {30'd0, cnt2};

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .wr_valid_i(wv), .wr_data_i(wd[7:0]), .wr_ready_o(rdy_w[0]),
        .txd_o(txd_w[0]), .busy_o(busy_w[0]), .fifo_count_o(cnt0), .done_o(done_w[0])
`ifdef UART_TX_BREAK_EN
        , .brk_i(brk)
`endif
    );

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(8)) u1 (
        .clk(clk), .rst(rst), .wr_valid_i(wv), .wr_data_i(wd[7:0]), .wr_ready_o(rdy_w[1]),
        .txd_o(txd_w[1]), .busy_o(busy_w[1]), .fifo_count_o(cnt1), .done_o(done_w[1])
`ifdef UART_TX_BREAK_EN
        , .brk_i(brk)
`endif
    );

    uart_tx_fifo #(.CLK_DIV(2), .DATA_BITS(5), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .wr_valid_i(wv), .wr_data_i(wd[4:0]), .wr_ready_o(rdy_w[2]),
        .txd_o(txd_w[2]), .busy_o(busy_w[2]), .fifo_count_o(cnt2), .done_o(done_w[2])
`ifdef UART_TX_BREAK_EN
        , .brk_i(brk)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int mq   [N][$];   // words waiting in the FIFO
    int wave [N][$];   // remaining per-cycle line levels of the active frame/gap
    bit isframe [N];
    bit brkf [N];

    int n_chk;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expand one word into its full line waveform, CLK_DIV cycles per bit.
    task automatic load_frame(input int i, input int w);
        int ones;
        int pb;
        ones = 0;
        wave[i].delete();
        repeat (cd[i]) wave[i].push_back(0);
        for (int k = 0; k < db[i]; k++) begin
            ones += (w >> k) & 1;
            repeat (cd[i]) wave[i].push_back((w >> k) & 1);
        end
        if (par[i] != 0) begin
            // odd: make total ones odd; even: make total ones even
            pb = (par[i] == 1) ? ((ones % 2 == 0) ? 1 : 0) : (ones % 2);
            repeat (cd[i]) wave[i].push_back(pb);
        end
        repeat (sb[i] * cd[i]) wave[i].push_back(1);
        isframe[i] = 1'b1;
    endtask

    task automatic model_step(input int i);
        int n;
        n = mq[i].size();
        if (rst) begin
            mq[i].delete();
            wave[i].delete();
            isframe[i] = 1'b0;
            brkf[i] = 1'b0;
            return;
        end
        if (wave[i].size() == 0) begin
`ifdef UART_TX_BREAK_EN
            if (brk) begin
                brkf[i] = 1'b1;
            end else if (brkf[i]) begin
                brkf[i] = 1'b0;
                repeat (cd[i] - 1) wave[i].push_back(1);
                isframe[i] = 1'b0;
            end else if (n > 0) begin
                load_frame(i, mq[i].pop_front());
            end
`else
            if (n > 0) load_frame(i, mq[i].pop_front());
`endif
        end else if (wave[i].size() == 1) begin
            if (n > 0) load_frame(i, mq[i].pop_front());
            else void'(wave[i].pop_front());
        end else begin
            void'(wave[i].pop_front());
        end
        if (wv && n < dep[i]) mq[i].push_back(int'(wd) & ((1 << db[i]) - 1));
    endtask

    task automatic check_all(input int i);
        int n;
        int w;
        logic exp_txd;
        n = mq[i].size();
        w = wave[i].size();
        exp_txd = 1'b1;
        if (w > 0) exp_txd = wave[i][0][0];
`ifdef UART_TX_BREAK_EN
        else if (brk) exp_txd = 1'b0;
`endif
        check($sformatf("u%0d txd", i), {31'd0, txd_w[i]}, {31'd0, exp_txd});
        check($sformatf("u%0d done", i), {31'd0, done_w[i]}, (w == 1 && isframe[i]) ? 32'd1 : 32'd0);
        check($sformatf("u%0d busy", i), {31'd0, busy_w[i]}, (w != 0 || n != 0) ? 32'd1 : 32'd0);
        check($sformatf("u%0d fifo_count", i), cnt_w[i], n);
        check($sformatf("u%0d wr_ready", i), {31'd0, rdy_w[i]}, (n < dep[i]) ? 32'd1 : 32'd0);
    endtask

    // One clock cycle: inputs were set just after the falling edge.
    task automatic cycle(input bit do_check);
        #1;
        if (do_check) begin
            for (int i = 0; i < N; i++) check_all(i);
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) model_step(i);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        wv = 1'b0;
        repeat (cycles) cycle(1'b1);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        wv  = 1'b0;
        wd  = '0;
`ifdef UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        @(negedge clk);
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);
        rst = 1'b0;

        // Single 0x55 frame, then the line returns to idle.
        wv = 1'b1; wd = 9'h055; cycle(1'b1);
        idle(70);

        // 0x07 on every configuration (even parity / two stop bits on u1).
        wv = 1'b1; wd = 9'h007; cycle(1'b1);
        idle(70);

        // Hold valid across 0x01..0x06: fills the shallow FIFOs to full.
        wv = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            wd = 9'(k);
            cycle(1'b1);
        end
        idle(450);

        // Keep writing while full: excess words must be dropped.
        wv = 1'b1;
        repeat (12) begin
            wd = 9'($urandom);
            cycle(1'b1);
        end
        idle(500);

        // Reset in the middle of the second frame, then a fresh write.
        wv = 1'b1; wd = 9'h0C3; cycle(1'b1);
        wd = 9'h13C; cycle(1'b1);
        idle(55);
        rst = 1'b1; cycle(1'b1);
        rst = 1'b0;
        wv = 1'b1; wd = 9'h05A; cycle(1'b1);
        idle(70);

`ifdef UART_TX_BREAK_EN
        // Break for 20 cycles while 0xA5 is queued.
        brk = 1'b1; wv = 1'b1; wd = 9'h0A5; cycle(1'b1);
        wv = 1'b0;
        repeat (19) cycle(1'b1);
        brk = 1'b0;
        idle(80);
`endif

        // Randomised traffic with varying write density and rare resets.
        for (int ph = 0; ph < 6; ph++) begin
            int thr;
            thr = $urandom_range(0, 6);
            repeat (500) begin
                wv  = ($urandom_range(0, thr) == 0);
                wd  = 9'($urandom);
                rst = ($urandom_range(0, 699) == 0);
`ifdef UART_TX_BREAK_EN
                brk = brk ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 299) == 0);
`endif
                cycle(1'b1);
            end
        end
        rst = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        idle(500);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
